// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and sizing for the iterative multiply/divide unit.
package mdu_pkg;
  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = $clog2(MDU_WIDTH);
  typedef enum logic [1:0] {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU} mdu_op_t;
  typedef enum logic [1:0] {MDU_IDLE, MDU_RUN, MDU_FINISH} mdu_state_t;
endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// mdu_sign_fix: turns the unsigned magnitude result into the final signed HI/LO pair.
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  mdu_op_t            i_op,
  input  logic               i_sa,
  input  logic               i_sb,
  output logic [WIDTH-1:0]   o_hi,
  output logic [WIDTH-1:0]   o_lo
);
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  // Sign flags are only ever set for signed ops, so no op gating is needed here.
  always_comb begin
    w_prod = (i_sa ^ i_sb) ? -i_acc : i_acc;
    w_quo = (i_sa ^ i_sb) ? -i_acc[WIDTH-1:0] : i_acc[WIDTH-1:0];
    w_rem = i_sa ? -i_acc[2*WIDTH-1:WIDTH] : i_acc[2*WIDTH-1:WIDTH];
    {o_hi, o_lo} = (i_op inside {MDU_DIV, MDU_DIVU}) ? {w_rem, w_quo} : w_prod;
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MULT/MULTU/DIV/DIVU engine producing HI/LO.
// One bit per cycle over a shared 2W register: product accumulator or {remainder, quotient}.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  mdu_state_t             r_state;
  mdu_state_t             w_state_nxt;
  mdu_op_t                r_op;
  logic [MDU_CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  logic                   r_sa;
  logic                   r_sb;
  logic                   w_signed;
  logic                   w_is_div;
  logic                   w_div_ge;
  logic                   w_dbz;
  logic [WIDTH-1:0]       w_abs_a;
  logic [WIDTH-1:0]       w_abs_b;
  logic [WIDTH:0]         w_msum;
  logic [WIDTH:0]         w_rsh;
  logic [WIDTH-1:0]       w_rdiff;
  logic [WIDTH-1:0]       w_fix_hi;
  logic [WIDTH-1:0]       w_fix_lo;

  assign busy = r_state != MDU_IDLE;

  always_comb begin
    w_signed = ~op[0];
    w_abs_a = (w_signed && a[WIDTH-1]) ? -a : a;
    w_abs_b = (w_signed && b[WIDTH-1]) ? -b : b;
    w_is_div = r_op inside {MDU_DIV, MDU_DIVU};
    w_msum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_rsh = r_acc[2*WIDTH-1:WIDTH-1];
    w_div_ge = w_rsh >= {1'b0, r_b};
    // Partial remainder stays below the divisor, so the W-bit truncation is exact.
    w_rdiff = w_div_ge ? WIDTH'(w_rsh - {1'b0, r_b}) : w_rsh[WIDTH-1:0];
    w_dbz = w_is_div && r_b == '0;
    w_state_nxt = r_state;
    case (r_state)
      MDU_IDLE:   w_state_nxt = start ? MDU_RUN : MDU_IDLE;
      MDU_RUN:    w_state_nxt = (r_cnt == '0) ? MDU_FINISH : MDU_RUN;
      default:    w_state_nxt = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= MDU_IDLE;
    else r_state <= w_state_nxt;
  end

  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .i_acc (r_acc),
    .i_op  (r_op),
    .i_sa  (r_sa),
    .i_sb  (r_sb),
    .o_hi  (w_fix_hi),
    .o_lo  (w_fix_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= MDU_MULT;
      r_cnt <= '0;
      r_acc <= '0;
      r_a <= '0;
      r_b <= '0;
      r_sa <= 1'b0;
      r_sb <= 1'b0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        MDU_IDLE: if (start) begin
          r_op <= mdu_op_t'(op);
          r_sa <= w_signed & a[WIDTH-1];
          r_sb <= w_signed & b[WIDTH-1];
          r_cnt <= MDU_CNT_W'(WIDTH - 1);
          r_a <= a;
          r_acc <= {{WIDTH{1'b0}}, op[1] ? w_abs_a : w_abs_b};
          r_b <= op[1] ? w_abs_b : w_abs_a;
          div_by_zero <= 1'b0;
        end
        MDU_RUN: begin
          r_cnt <= r_cnt - 1'b1;
          r_acc <= w_is_div ? {w_rdiff, r_acc[WIDTH-2:0], w_div_ge} : {w_msum, r_acc[WIDTH-1:1]};
        end
        MDU_FINISH: begin
          done <= 1'b1;
          hi <= w_dbz ? r_a : w_fix_hi;
          lo <= w_dbz ? '1 : w_fix_lo;
          div_by_zero <= w_dbz;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit against a $signed/$unsigned model.
module tb_mult_div_unit;
  localparam int W = 32;
  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;
  exp_t         sb_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [2*W-1:0] p;
    e.dbz = 1'b0;
    e.hi = '0;
    e.lo = '0;
    if (o == 2'd0) begin
      p = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
      {e.hi, e.lo} = p;
    end else if (o == 2'd1) begin
      p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      {e.hi, e.lo} = p;
    end else if (y == '0) begin
      e.hi = x;
      e.lo = '1;
      e.dbz = 1'b1;
    end else if (o == 2'd2) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        e.lo = x;
        e.hi = '0;
      end else begin
        e.lo = $signed(x) / $signed(y);
        e.hi = $signed(x) % $signed(y);
      end
    end else begin
      e.lo = x / y;
      e.hi = x % y;
    end
    return e;
  endfunction

  task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb_q.push_back(model(o, x, y));
  endtask

  task automatic wait_done(input int inj, output int lat, output bit bsy_ok);
    lat = -1;
    bsy_ok = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (inj != 0 && n == inj) begin
        op = 2'd3;
        a = 32'd999;
        b = 32'd7;
        start = 1'b1;
      end
      if (inj != 0 && n == inj + 1) start = 1'b0;
      if (done) begin
        lat = n;
        return;
      end
      if (!busy) bsy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 000", {busy, done, div_by_zero});
    end
    n_cmp++;
    if ({hi, lo} !== '0) begin
      n_bad++;
      $display("FAIL reset_hilo got %h_%h want 0", hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mult_basic();
    exp_t e;
    int lat;
    bit ok;
    @(negedge clk);
    start_op(2'd0, 32'd7, 32'd6);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mult_busy_accept got %b want 1", busy);
    end
    wait_done(0, lat, ok);
    n_cmp++;
    if (lat !== 33) begin
      n_bad++;
      $display("FAIL mult_latency got %0d want 33", lat);
    end
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("FAIL mult_busy_held got %b want 1", ok);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mult_busy_done got %b want 0", busy);
    end
    e = sb_q.pop_front();
    n_cmp++;
    if ({hi, lo, div_by_zero} !== e) begin
      n_bad++;
      $display("FAIL mult_7x6 got %h_%h/%b want %h_%h/%b", hi, lo, div_by_zero, e.hi, e.lo, e.dbz);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({hi, lo} !== {e.hi, e.lo}) begin
      n_bad++;
      $display("FAIL hold_idle got %h_%h want %h_%h", hi, lo, e.hi, e.lo);
    end
  endtask

  task automatic test_pairs(input string name, input logic [1:0] o1, input logic [W-1:0] x1, input logic [W-1:0] y1,
                            input logic [1:0] o2, input logic [W-1:0] x2, input logic [W-1:0] y2);
    exp_t e;
    int lat;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (k == 0) start_op(o1, x1, y1);
      else start_op(o2, x2, y2);
      wait_done(0, lat, ok);
      n_cmp++;
      if (lat !== 33) begin
        n_bad++;
        $display("FAIL %s_lat%0d got %0d want 33", name, k, lat);
      end
      e = sb_q.pop_front();
      n_cmp++;
      if ({hi, lo, div_by_zero} !== e) begin
        n_bad++;
        $display("FAIL %s_res%0d got %h_%h/%b want %h_%h/%b", name, k, hi, lo, div_by_zero, e.hi, e.lo, e.dbz);
      end
    end
  endtask

  task automatic test_div_zero();
    exp_t e;
    int lat;
    bit ok;
    @(negedge clk);
    start_op(2'd3, 32'd100, 32'd0);
    wait_done(0, lat, ok);
    e = sb_q.pop_front();
    n_cmp++;
    if ({hi, lo, div_by_zero} !== e || lat !== 33) begin
      n_bad++;
      $display("FAIL divz_res got %h_%h/%b lat %0d want %h_%h/%b lat 33", hi, lo, div_by_zero, lat, e.hi, e.lo, e.dbz);
    end
    @(negedge clk);
    start_op(2'd0, 32'd3, 32'd5);
    n_cmp++;
    if (div_by_zero !== 1'b0) begin
      n_bad++;
      $display("FAIL divz_clear got %b want 0", div_by_zero);
    end
    wait_done(0, lat, ok);
    e = sb_q.pop_front();
    n_cmp++;
    if ({hi, lo, div_by_zero} !== e) begin
      n_bad++;
      $display("FAIL divz_next got %h_%h/%b want %h_%h/%b", hi, lo, div_by_zero, e.hi, e.lo, e.dbz);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat;
    bit ok;
    @(negedge clk);
    start_op(2'd0, 32'd123457, 32'hFFFF_FF9D);
    wait_done(5, lat, ok);
    e = sb_q.pop_front();
    n_cmp++;
    if ({hi, lo, div_by_zero} !== e || lat !== 33) begin
      n_bad++;
      $display("FAIL ignore_start got %h_%h/%b lat %0d want %h_%h/%b lat 33", hi, lo, div_by_zero, lat, e.hi, e.lo, e.dbz);
    end
    start_op(2'd3, 32'd1000, 32'd33);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_accept got busy %b want 1", busy);
    end
    wait_done(0, lat, ok);
    e = sb_q.pop_front();
    n_cmp++;
    if ({hi, lo, div_by_zero} !== e || lat !== 33) begin
      n_bad++;
      $display("FAIL b2b_res got %h_%h/%b lat %0d want %h_%h/%b lat 33", hi, lo, div_by_zero, lat, e.hi, e.lo, e.dbz);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(negedge clk);
    start_op(2'd1, 32'd5, 32'd9);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    n_cmp++;
    if ({busy, done, div_by_zero, hi, lo} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid got busy %b done %b dbz %b hi %h lo %h want all 0", busy, done, div_by_zero, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL rst_no_done got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_random();
    exp_t e;
    int lat;
    bit ok;
    logic [1:0] o;
    logic [W-1:0] x, y;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      x = (i % 7 == 3) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       y = '0;
        1:       y = '1;
        2:       y = 32'($urandom_range(1, 20));
        default: y = $urandom;
      endcase
      @(negedge clk);
      start_op(o, x, y);
      wait_done(0, lat, ok);
      e = sb_q.pop_front();
      n_cmp++;
      if ({hi, lo, div_by_zero} !== e || lat !== 33) begin
        n_bad++;
        $display("FAIL rand%0d op %0d a %h b %h got %h_%h/%b lat %0d want %h_%h/%b", i, o, x, y, hi, lo, div_by_zero, lat, e.hi, e.lo, e.dbz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult_basic();
    test_pairs("mult_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    test_pairs("div_basic", 2'd2, 32'hFFFF_FFF9, 32'd2, 2'd3, 32'd7, 32'd2);
    test_pairs("div_edge", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 2'd2, 32'd7, 32'hFFFF_FFFE);
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
